// File: rtl/reg_file_16b.sv
// Operand register file and carry flag for the 16-bit single-cycle CPU:
// two combinational ALU read ports, one debug read port, one synchronous write port.
module reg_file_16b #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              cf_we,
    input  logic              cf_clr,
    input  logic              cf_in,
    output logic              cf,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic R0_IS_ZERO = (ZERO_R0 != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic              cf_q;
    logic              wr_en;

    // Writes to r0 are dropped when r0 is hard-wired to zero.
    assign wr_en = we && !(R0_IS_ZERO && (wa == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cf_q <= 1'b0;
        end else if (cf_clr) begin
            cf_q <= 1'b0;
        end else if (cf_we) begin
            cf_q <= cf_in;
        end
    end

    // No write bypass: a read during a write to the same address sees the old value.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] stored);
        if (R0_IS_ZERO && (addr == '0)) begin
            return '0;
        end
        return stored;
    endfunction

    assign rd1      = read_port(ra1, regs[ra1]);
    assign rd2      = read_port(ra2, regs[ra2]);
    assign dbg_data = read_port(dbg_addr, regs[dbg_addr]);
    assign cf       = cf_q;

endmodule
